// File: rtl/sample_tick_fetcher.sv
// Turns the speed-controller divisor into a periodic sample tick and emits one
// byte per tick from a word buffer refilled over a req/ack handshake.
// Optional feature: define OVERRUN_COUNT_EN to add a saturating overrun_count output.
module sample_tick_fetcher #(
  parameter int unsigned DIV_DEFAULT = 1227,
  parameter int unsigned DIV_MIN     = 64,
  parameter int unsigned DIV_MAX     = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] divisor,
  output logic        fetch_req,
  input  logic        fetch_ack,
  input  logic [31:0] fetch_data,
  output logic        tick,
  output logic [7:0]  sample_out,
  output logic        sample_valid,
  output logic        overrun
`ifdef OVERRUN_COUNT_EN
  ,
  output logic [15:0] overrun_count
`endif
);

  localparam logic [15:0] DIV_DEFAULT_W = 16'(DIV_DEFAULT);
  localparam logic [15:0] DIV_MIN_W     = 16'(DIV_MIN);
  localparam logic [15:0] DIV_MAX_W     = 16'(DIV_MAX);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] active_div_q, active_div_d;
  logic [15:0] eff_div;
  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic        fetch_req_q, fetch_req_d;
  logic        tick_q, tick_d;
  logic [7:0]  sample_q, sample_d;
  logic        valid_q, valid_d;
  logic        overrun_q, overrun_d;
`ifdef OVERRUN_COUNT_EN
  logic [15:0] ovc_q, ovc_d;
`endif

  // Divisor clamp: full 32-bit unsigned comparison against the accepted range
  always_comb begin
    eff_div = divisor[15:0];
    if (divisor < DIV_MIN) begin
      eff_div = DIV_MIN_W;
    end else if (divisor > DIV_MAX) begin
      eff_div = DIV_MAX_W;
    end else begin
      eff_div = divisor[15:0];
    end
  end

  // Divider: the new divisor is only picked up at a period boundary
  always_comb begin
    count_d      = count_q;
    active_div_d = active_div_q;
    tick_d       = 1'b0;
    if (enable) begin
      if (count_q == active_div_q - 16'd1) begin
        tick_d       = 1'b1;
        count_d      = 16'd0;
        active_div_d = eff_div;
      end else begin
        count_d = count_q + 16'd1;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Buffer FSM: a tick with no word buffered is reported as overrun, never skips a byte
  always_comb begin
    state_d     = state_q;
    fetch_req_d = fetch_req_q;
    word_d      = word_q;
    idx_d       = idx_q;
    sample_d    = sample_q;
    valid_d     = 1'b0;
    overrun_d   = 1'b0;
    case (state_q)
      ST_REQ: begin
        fetch_req_d = 1'b1;
        overrun_d   = tick_d;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        overrun_d = tick_d;
        if (fetch_ack) begin
          word_d      = fetch_data;
          idx_d       = 2'd0;
          fetch_req_d = 1'b0;
          state_d     = ST_FULL;
        end else begin
          fetch_req_d = 1'b1;
        end
      end
      ST_FULL: begin
        if (tick_d) begin
          sample_d = 8'(word_q >> {idx_q, 3'b000});
          valid_d  = 1'b1;
          idx_d    = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_FULL;
          end
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        fetch_req_d = 1'b0;
        state_d     = ST_REQ;
      end
    endcase
  end

`ifdef OVERRUN_COUNT_EN
  // Overrun counter saturates instead of wrapping
  always_comb begin
    if (overrun_d && (ovc_q != 16'hFFFF)) begin
      ovc_d = ovc_q + 16'd1;
    end else begin
      ovc_d = ovc_q;
    end
  end
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_REQ;
      count_q      <= 16'd0;
      active_div_q <= DIV_DEFAULT_W;
      word_q       <= 32'd0;
      idx_q        <= 2'd0;
      fetch_req_q  <= 1'b0;
      tick_q       <= 1'b0;
      sample_q     <= 8'd0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef OVERRUN_COUNT_EN
      ovc_q        <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      active_div_q <= active_div_d;
      word_q       <= word_d;
      idx_q        <= idx_d;
      fetch_req_q  <= fetch_req_d;
      tick_q       <= tick_d;
      sample_q     <= sample_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
`ifdef OVERRUN_COUNT_EN
      ovc_q        <= ovc_d;
`endif
    end
  end

  assign fetch_req    = fetch_req_q;
  assign tick         = tick_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
`ifdef OVERRUN_COUNT_EN
  assign overrun_count = ovc_q;
`endif

endmodule

// File: tb/tb_sample_tick_fetcher.sv
// Bench for sample_tick_fetcher: queue-based reference model checked every cycle,
// a divisor/period vector table, and directed sequences for the multi-cycle corners.
module tb_sample_tick_fetcher;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] divisor = 32'd1227;
  logic        fetch_ack = 1'b0;
  logic [31:0] fetch_data = 32'd0;
  logic        fetch_req, tick, sample_valid, overrun;
  logic [7:0]  sample_out;
`ifdef OVERRUN_COUNT_EN
  logic [15:0] overrun_count;
`endif

  always #5 clk = ~clk;

  sample_tick_fetcher dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .divisor      (divisor),
    .fetch_req    (fetch_req),
    .fetch_ack    (fetch_ack),
    .fetch_data   (fetch_data),
    .tick         (tick),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .overrun      (overrun)
`ifdef OVERRUN_COUNT_EN
    ,
    .overrun_count(overrun_count)
`endif
  );

  int total = 0;
  int bad = 0;

  // Reference model: elapsed clocks in the current period plus a byte queue
  byte unsigned bq[$];
  int          m_phase, m_period, m_ovc;
  bit          m_req, m_tick, m_valid, m_ovr;
  logic [7:0]  m_sample;

  int          ack_delay = 2;
  int          req_age = 0;
  bit          spurious = 1'b0;
  logic [31:0] next_data = 32'h44332211;

  typedef struct {
    logic [31:0] div;
    int          exp_period;
  } vec_t;
  vec_t tbl[6];

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      if (bad >= 40) finish_run();
    end
  endtask

  function automatic int clamp(input logic [31:0] d);
    if (d < 32'd64) return 64;
    if (d > 32'd65535) return 65535;
    return int'(d);
  endfunction

  task automatic model_reset();
    bq.delete();
    m_phase = 0; m_period = 1227; m_ovc = 0;
    m_req = 1'b0; m_tick = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
    m_sample = 8'd0;
    req_age = 0;
  endtask

  task automatic model_edge();
    bit pre_empty, req_pre;
    pre_empty = (bq.size() == 0);
    req_pre   = m_req;
    m_tick = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
    if (enable) begin
      if (m_phase + 1 == m_period) begin
        m_tick = 1'b1;
        m_phase = 0;
        m_period = clamp(divisor);
      end else begin
        m_phase++;
      end
    end
    if (m_tick) begin
      if (bq.size() > 0) begin
        m_sample = bq.pop_front();
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
        if (m_ovc < 65535) m_ovc++;
      end
    end
    if (fetch_ack && req_pre) begin
      for (int i = 0; i < 4; i++) bq.push_back(fetch_data[8*i +: 8]);
      m_req = 1'b0;
    end else if (pre_empty && !req_pre) begin
      m_req = 1'b1;
    end
  endtask

  task automatic compare_outputs();
    check("tick", 32'(tick), 32'(m_tick));
    check("sample_valid", 32'(sample_valid), 32'(m_valid));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("fetch_req", 32'(fetch_req), 32'(m_req));
    check("sample_out", 32'(sample_out), 32'(m_sample));
`ifdef OVERRUN_COUNT_EN
    check("overrun_count", 32'(overrun_count), 32'(m_ovc));
`endif
  endtask

  task automatic drive_ack();
    if (m_req) req_age++;
    else req_age = 0;
    fetch_ack = 1'b0;
    if (m_req && ack_delay >= 0 && req_age > ack_delay) begin
      fetch_ack = 1'b1;
      fetch_data = next_data;
      next_data = $urandom;
    end else if (spurious && !m_req && $urandom_range(0, 15) == 0) begin
      fetch_ack = 1'b1;
      fetch_data = $urandom;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_outputs();
    drive_ack();
  endtask

  task automatic wait_tick(output int n, input int budget);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < budget);
    if (!tick) check("tick_timeout", 32'(tick), 32'd1);
  endtask

  initial begin
    int n;
    int ticks_seen;
    int guard;
    logic [7:0] saved_sample;

    tbl[0] = '{32'd10,          64};
    tbl[1] = '{32'd63,          64};
    tbl[2] = '{32'd64,          64};
    tbl[3] = '{32'd65,          65};
    tbl[4] = '{32'd300,         300};
    tbl[5] = '{32'h0001_0000,   65535};

    // Reset values
    model_reset();
    reset_n = 1'b0; enable = 1'b1; divisor = 32'd1227;
    repeat (3) @(negedge clk);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_sample_out", 32'(sample_out), 32'd0);
    check("rst_sample_valid", 32'(sample_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_fetch_req", 32'(fetch_req), 32'd0);
    reset_n = 1'b1;

    // Default period and byte order within a word
    for (int k = 0; k < 4; k++) begin
      wait_tick(n, 2000);
      check("t1_period", 32'(n), 32'd1227);
      check("t1_sample", 32'(sample_out), 32'(17 * (k + 1)));
      check("t1_valid", 32'(sample_valid), 32'd1);
    end
    step();
    check("t1_req_rise", 32'(fetch_req), 32'd1);

    // Clamp table: each period uses the divisor present at its opening boundary
    divisor = tbl[0].div;
    wait_tick(n, 2000);
    for (int i = 0; i < 6; i++) begin
      divisor = (i < 5) ? tbl[i + 1].div : 32'd1227;
      wait_tick(n, 70000);
      check("t2_period", 32'(n), 32'(tbl[i].exp_period));
    end

    // Mid-period divisor change is deferred to the next boundary
    repeat (300) step();
    divisor = 32'd1231;
    wait_tick(n, 2000);
    check("t3_current", 32'(n + 300), 32'd1227);
    divisor = 32'd64;
    wait_tick(n, 2000);
    check("t3_next", 32'(n), 32'd1231);

    // Withheld ack across a tick
    ack_delay = -1;
    saved_sample = m_sample;
    for (int k = 0; k < 6; k++) begin
      saved_sample = m_sample;
      wait_tick(n, 200);
      if (overrun) break;
    end
    check("t4_overrun", 32'(overrun), 32'd1);
    check("t4_valid_low", 32'(sample_valid), 32'd0);
    check("t4_sample_hold", 32'(sample_out), 32'(saved_sample));
    step();
    check("t4_once", 32'(overrun), 32'd0);
    next_data = 32'hDDCCBBAA;
    ack_delay = 2;
    wait_tick(n, 200);
    check("t4_byte0", 32'(sample_out), 32'hAA);
    check("t4_byte0_valid", 32'(sample_valid), 32'd1);

    // Pause holds the count; resume finishes the same period
    divisor = 32'd1227;
    wait_tick(n, 200);
    repeat (400) step();
    enable = 1'b0;
    ticks_seen = 0;
    repeat (500) begin
      step();
      if (tick) ticks_seen++;
    end
    check("t5_paused", 32'(ticks_seen), 32'd0);
    divisor = 32'd64;
    enable = 1'b1;
    wait_tick(n, 2000);
    check("t5_resume", 32'(n), 32'd827);

    // Reset while waiting for the ack
    ack_delay = -1;
    guard = 0;
    while (!m_req && guard < 3000) begin
      step();
      guard++;
    end
    step();
    check("t6_in_wait", 32'(fetch_req), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_req_drop", 32'(fetch_req), 32'd0);
    check("t6_tick", 32'(tick), 32'd0);
    check("t6_sample", 32'(sample_out), 32'd0);
    check("t6_valid", 32'(sample_valid), 32'd0);
    check("t6_overrun", 32'(overrun), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    divisor = 32'd100;
    ack_delay = 2;
    fetch_ack = 1'b0;
    reset_n = 1'b1;
    step();
    check("t6_req_back", 32'(fetch_req), 32'd1);
    wait_tick(n, 2000);
    check("t6_default_div", 32'(n + 1), 32'd1227);
    wait_tick(n, 2000);
    check("t6_new_div", 32'(n), 32'd100);

    // Randomized traffic against the model
    spurious = 1'b1;
    repeat (30) begin
      divisor = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 63))
                                            : 32'($urandom_range(64, 140));
      ack_delay = int'($urandom_range(0, 160));
      enable = ($urandom_range(0, 7) != 0);
      repeat ($urandom_range(50, 200)) step();
    end

    finish_run();
  end

endmodule

// File: doc/sample_tick_fetcher.md
Name: sample_tick_fetcher

Overview:
- Consumer side of the playback-speed interface: takes the 32-bit clock-divider value produced by the speed controller and turns it into a periodic one-cycle sample tick.
- On each tick, emits the next 8-bit audio sample taken from a 32-bit word buffer.
- Refills that buffer through a req/ack handshake with the flash/memory reader.
- Sits between speed control, memory reader and audio output.

Parameters:
- DIV_DEFAULT, 1227, divisor used out of reset.
- DIV_MIN, 64, lowest accepted divisor (clamp floor).
- DIV_MAX, 65535, highest accepted divisor (clamp ceiling).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  playback enable; low pauses ticks
- divisor  in  32  requested clocks per sample (from speed controller)
- fetch_req  out  1  request next 32-bit word
- fetch_ack  in  1  one-cycle strobe; fetch_data valid this cycle
- fetch_data  in  32  word from memory reader
- tick  out  1  one-cycle sample-period strobe
- sample_out  out  8  current sample
- sample_valid  out  1  one-cycle strobe, sample_out updated
- overrun  out  1  one-cycle strobe, tick with empty buffer

Behaviour:
- Reset (async, reset_n low) values:
  - divider count = 0; active_div = DIV_DEFAULT.
  - tick = 0, sample_out = 0, sample_valid = 0, overrun = 0.
  - byte index = 0; FSM = REQ; fetch_req = 0 during reset.
- Clamp: eff_div = DIV_MIN if divisor < DIV_MIN; DIV_MAX if divisor > DIV_MAX; else divisor. Comparison is 32-bit unsigned.
- Divider:
  - While enable = 1, count increments each clk. When count == active_div-1: tick = 1 next cycle, count <- 0, active_div <- eff_div.
  - Divisor changes take effect only at a period boundary; a period in progress is never shortened or stretched.
  - Tick period is exactly active_div clocks.
  - enable = 0: count held, no ticks. Re-enable resumes from the held count.
- FSM states: REQ, WAIT, FULL.
  - REQ: fetch_req = 1, go to WAIT next cycle.
  - WAIT: fetch_req stays 1 until fetch_ack. On fetch_ack: word <- fetch_data, idx <- 0, fetch_req <- 0, go to FULL.
  - FULL, on tick: sample_out <- word[8*idx+7 : 8*idx] (byte 0 = bits 7:0), sample_valid = 1, idx <- idx+1. If idx was 3, go to REQ.
- Latency: sample_out and sample_valid update in the cycle after the tick, aligned with the tick output.
- Tick while in REQ or WAIT:
  - overrun = 1 for one cycle.
  - sample_out holds its previous value; sample_valid = 0.
  - The fetch continues; no byte is skipped.
- Tick in the same cycle as fetch_ack: the word loads and the tick counts as overrun. The first byte is emitted on the next tick.
- fetch_ack outside WAIT is ignored.
- enable = 0 never aborts an outstanding fetch: WAIT still completes on fetch_ack.
- Reset asserted mid-fetch drops fetch_req immediately; the FSM restarts in REQ.

Optional Feature:
- Macro: OVERRUN_COUNT_EN.
- Defined:
  - Adds output overrun_count [15:0], reset 0.
  - Increments on each overrun strobe and saturates at 16'hFFFF.
- Undefined: the port and its counter do not exist.

Test Plan:
1. Reset, enable = 1, divisor = 1227, ack fetch with 32'h44332211 two cycles after req → ticks every 1227 clks. sample_out sequence 11, 22, 33, 44 with one sample_valid per tick. fetch_req rises in the cycle after the 4th sample.
2. divisor = 10 (below DIV_MIN) → tick spacing 64 clks. divisor = 32'h0001_0000 → spacing 65535 clks.
3. Change divisor 1227 → 1231 mid-period → the current period stays 1227; the next period is 1231.
4. Withhold fetch_ack across a tick → overrun pulses once, sample_valid = 0, sample_out unchanged. After the ack, the next tick emits byte 0 of the new word.
5. enable low for 500 clks mid-period → no ticks during the pause; the first tick after re-enable comes at (active_div - held count) clks.
6. Assert reset_n low while in WAIT → fetch_req = 0 and all outputs = 0 immediately. After release, fetch_req reasserts and the divisor is 1227.
